// File: rtl/ctrl_progmem_pkg.sv
// Shared definitions for the controller program memory: instruction width derivation
// and the loader FSM state encoding.
package ctrl_progmem_pkg;

  function automatic int unsigned instr_width(input int unsigned vec_w,
                                              input int unsigned reg_w,
                                              input int unsigned dat_w);
    return 2 + vec_w + 2 * reg_w + 3 * dat_w;
  endfunction

  localparam int unsigned INSTR_WIDTH = instr_width(3, 3, 4);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StErr  = 2'd3
  } state_e;

endpackage

// File: rtl/ctrl_imem.sv
// Simple dual-port instruction store: synchronous write, registered read, no reset.
module ctrl_imem #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WIDTH      = 23
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ctrl_progmem.sv
// Program memory with a streaming loader FSM and a one-cycle-latency fetch port.
module ctrl_progmem
  import ctrl_progmem_pkg::*;
#(
  parameter int unsigned VEC_ID_WIDTH       = 3,
  parameter int unsigned REGFILE_ADDR_WIDTH = 3,
  parameter int unsigned DATA_ADDR_WIDTH    = 4,
  parameter int unsigned INSTR_ADDR_WIDTH   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   prog,
  input  logic                                   ld_valid,
  output logic                                   ld_ready,
  input  logic [instr_width(VEC_ID_WIDTH, REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH)-1:0] ld_word,
  input  logic                                   ld_last,
  input  logic [INSTR_ADDR_WIDTH-1:0]            pc,
  input  logic                                   fetch,
  output logic [instr_width(VEC_ID_WIDTH, REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH)-1:0] instr_word,
  output logic [INSTR_ADDR_WIDTH:0]              prog_len,
  output logic                                   prog_done,
  output logic                                   ld_err
);

  localparam int unsigned IW = instr_width(VEC_ID_WIDTH, REGFILE_ADDR_WIDTH, DATA_ADDR_WIDTH);
  localparam logic [INSTR_ADDR_WIDTH:0] DepthLen =
      (INSTR_ADDR_WIDTH+1)'(1 << INSTR_ADDR_WIDTH);
  localparam logic [INSTR_ADDR_WIDTH-1:0] MaxAddr = {INSTR_ADDR_WIDTH{1'b1}};

  state_e                      state;
  logic [INSTR_ADDR_WIDTH-1:0] wptr;
  logic                        prog_q;
  logic                        rd_ok;
  logic [IW-1:0]               rdata;

  logic xfer, prog_rise, rd_hit;
  assign xfer      = (state == StLoad) && ld_valid && ld_ready;
  assign prog_rise = prog && !prog_q;
  assign rd_hit    = (state == StRun) && !prog && ({1'b0, pc} < prog_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      wptr      <= '0;
      prog_len  <= '0;
      prog_done <= 1'b0;
      ld_err    <= 1'b0;
      ld_ready  <= 1'b0;
      prog_q    <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      prog_q <= prog;
      // rd_ok qualifies the memory read register; a miss forces zeros at the output.
      if (fetch) rd_ok <= rd_hit;
      unique case (state)
        StIdle: begin
          if (prog) begin
            state    <= StLoad;
            wptr     <= '0;
            prog_len <= '0;
            ld_ready <= 1'b1;
          end
        end
        StLoad: begin
          if (xfer) begin
            if (wptr != MaxAddr) wptr <= wptr + 1'b1;
            if (prog_len != DepthLen) prog_len <= prog_len + 1'b1;
            if (ld_last) begin
              state     <= StRun;
              prog_done <= 1'b1;
              ld_ready  <= 1'b0;
            end else if (wptr == MaxAddr || !prog) begin
              state    <= StErr;
              ld_err   <= 1'b1;
              ld_ready <= 1'b0;
            end
          end else if (!prog) begin
            state    <= StErr;
            ld_err   <= 1'b1;
            ld_ready <= 1'b0;
          end
        end
        StRun: begin
          if (prog_rise) begin
            state     <= StLoad;
            prog_done <= 1'b0;
            ld_ready  <= 1'b1;
            wptr      <= '0;
            prog_len  <= '0;
          end
        end
        StErr: begin
          if (prog_rise) begin
            state    <= StLoad;
            ld_err   <= 1'b0;
            ld_ready <= 1'b1;
            wptr     <= '0;
            prog_len <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  ctrl_imem #(
    .ADDR_WIDTH (INSTR_ADDR_WIDTH),
    .WIDTH      (IW)
  ) u_imem (
    .clk   (clk),
    .we    (xfer),
    .waddr (wptr),
    .wdata (ld_word),
    .re    (fetch && rd_hit),
    .raddr (pc),
    .rdata (rdata)
  );

  assign instr_word = rd_ok ? rdata : '0;

endmodule

// File: tb/tb_ctrl_progmem.sv
// Directed self-checking bench for ctrl_progmem.
module tb_ctrl_progmem;

  localparam int IW = 23;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [IW-1:0] ld_word = '0;
  logic          ld_last = 1'b0;
  logic [3:0]    pc = '0;
  logic          fetch = 1'b0;
  logic [IW-1:0] instr_word;
  logic [4:0]    prog_len;
  logic          prog_done;
  logic          ld_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_progmem dut (
    .clk        (clk),
    .rst        (rst),
    .prog       (prog),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_word    (ld_word),
    .ld_last    (ld_last),
    .pc         (pc),
    .fetch      (fetch),
    .instr_word (instr_word),
    .prog_len   (prog_len),
    .prog_done  (prog_done),
    .ld_err     (ld_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] w, input logic last);
    ld_valid = 1'b1;
    ld_word  = w;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_fetch(input logic [3:0] a);
    fetch = 1'b1;
    pc    = a;
    step();
    fetch = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({ld_ready, prog_done, ld_err, prog_len, instr_word} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b done=%b err=%b len=%0d iw=%h, want all 0",
               ld_ready, prog_done, ld_err, prog_len, instr_word);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got %b want 0", ld_ready);
    end
  endtask

  task automatic test_load5();
    prog = 1'b1;
    step();
    checks++;
    if (ld_ready !== 1'b1 || prog_len !== 5'd0) begin
      errors++;
      $display("FAIL load_entry: got rdy=%b len=%0d want rdy=1 len=0", ld_ready, prog_len);
    end
    for (int i = 1; i <= 5; i++) push(IW'(i), i == 5);
    checks++;
    if (prog_len !== 5'd5 || prog_done !== 1'b1 || ld_ready !== 1'b0 || ld_err !== 1'b0) begin
      errors++;
      $display("FAIL load5_status: got len=%0d done=%b rdy=%b err=%b want 5 1 0 0",
               prog_len, prog_done, ld_ready, ld_err);
    end
    // prog still high: reads not honoured
    do_fetch(4'd0);
    checks++;
    if (instr_word !== '0) begin
      errors++;
      $display("FAIL fetch_prog_high: got %h want 0", instr_word);
    end
    prog = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      do_fetch(4'(i));
      checks++;
      if (instr_word !== IW'(i + 1)) begin
        errors++;
        $display("FAIL load5_read[%0d]: got %h want %h", i, instr_word, IW'(i + 1));
      end
    end
  endtask

  task automatic test_overflow();
    prog = 1'b1;
    step();
    do_fetch(4'd0);
    checks++;
    if (instr_word !== '0 || ld_ready !== 1'b1 || prog_done !== 1'b0) begin
      errors++;
      $display("FAIL reload_entry: got iw=%h rdy=%b done=%b want 0 1 0",
               instr_word, ld_ready, prog_done);
    end
    for (int i = 0; i < 15; i++) push(IW'(32'h200 + i), 1'b0);
    checks++;
    if (ld_err !== 1'b0 || prog_len !== 5'd15 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL pre_overflow: got err=%b len=%0d rdy=%b want 0 15 1",
               ld_err, prog_len, ld_ready);
    end
    push(IW'(32'h20F), 1'b0);
    checks++;
    if (ld_err !== 1'b1 || prog_done !== 1'b0 || prog_len !== 5'd16 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow: got err=%b done=%b len=%0d rdy=%b want 1 0 16 0",
               ld_err, prog_done, prog_len, ld_ready);
    end
    prog = 1'b0;
    step();
  endtask

  task automatic test_truncate();
    prog = 1'b1;
    step();
    checks++;
    if (ld_err !== 1'b0 || ld_ready !== 1'b1 || prog_len !== 5'd0) begin
      errors++;
      $display("FAIL err_recover: got err=%b rdy=%b len=%0d want 0 1 0",
               ld_err, ld_ready, prog_len);
    end
    for (int i = 0; i < 3; i++) push(IW'(32'h300 + i), 1'b0);
    prog = 1'b0;
    step();
    checks++;
    if (ld_err !== 1'b1 || ld_ready !== 1'b0 || prog_done !== 1'b0 || prog_len !== 5'd3) begin
      errors++;
      $display("FAIL truncate: got err=%b rdy=%b done=%b len=%0d want 1 0 0 3",
               ld_err, ld_ready, prog_done, prog_len);
    end
    prog = 1'b1;
    step();
    checks++;
    if (ld_err !== 1'b0 || ld_ready !== 1'b1 || prog_len !== 5'd0) begin
      errors++;
      $display("FAIL truncate_recover: got err=%b rdy=%b len=%0d want 0 1 0",
               ld_err, ld_ready, prog_len);
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 4; i++) push(IW'(32'h100 + i), i == 3);
    prog = 1'b0;
    step();
    do_fetch(4'd3);
    checks++;
    if (instr_word !== IW'(32'h103)) begin
      errors++;
      $display("FAIL read4_last: got %h want 000103", instr_word);
    end
    pc = 4'd1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (instr_word !== IW'(32'h103)) begin
      errors++;
      $display("FAIL hold_valid: got %h want 000103", instr_word);
    end
    do_fetch(4'd7);
    checks++;
    if (instr_word !== '0) begin
      errors++;
      $display("FAIL fetch_oob: got %h want 0", instr_word);
    end
    pc = 4'd0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (instr_word !== '0) begin
      errors++;
      $display("FAIL hold_oob: got %h want 0", instr_word);
    end
    do_fetch(4'd4);
    checks++;
    if (instr_word !== '0) begin
      errors++;
      $display("FAIL fetch_at_len: got %h want 0", instr_word);
    end
    do_fetch(4'd0);
    checks++;
    if (instr_word !== IW'(32'h100)) begin
      errors++;
      $display("FAIL read4_first: got %h want 000100", instr_word);
    end
  endtask

  task automatic test_reset_midload();
    prog = 1'b1;
    step();
    push(IW'(32'h500), 1'b0);
    push(IW'(32'h501), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ld_ready, prog_done, ld_err, prog_len, instr_word} !== '0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b done=%b err=%b len=%0d iw=%h, want all 0",
               ld_ready, prog_done, ld_err, prog_len, instr_word);
    end
    #1;
    rst = 1'b0;
    step();
    checks++;
    if (ld_ready !== 1'b1 || prog_len !== 5'd0) begin
      errors++;
      $display("FAIL reset_prog_high: got rdy=%b len=%0d want 1 0", ld_ready, prog_len);
    end
  endtask

  task automatic test_random_valid();
    int cnt = 0;
    int cyc = 0;
    logic acc;
    while (cnt < 8 && cyc < 200) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_word  = IW'(32'h4A0000 + cnt);
      ld_last  = (cnt == 7);
      acc      = ld_valid && ld_ready;
      step();
      if (acc) cnt++;
      cyc++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL random_timeout: transferred %0d want 8", cnt);
    end
    checks++;
    if (prog_len !== 5'd8 || prog_done !== 1'b1 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL random_status: got len=%0d done=%b rdy=%b want 8 1 0",
               prog_len, prog_done, ld_ready);
    end
    prog = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      do_fetch(4'(i));
      checks++;
      if (instr_word !== IW'(32'h4A0000 + i)) begin
        errors++;
        $display("FAIL random_read[%0d]: got %h want %h", i, instr_word, IW'(32'h4A0000 + i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load5();
    test_overflow();
    test_truncate();
    test_out_of_range();
    test_reset_midload();
    test_random_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_progmem.md
CTRL_PROGMEM -- requirements
Module: ctrl_progmem

Interface
REQ-001 SHALL have parameter VEC_ID_WIDTH, default 3, vector-id field width.
REQ-002 SHALL have parameter REGFILE_ADDR_WIDTH, default 3, register-address field width.
REQ-003 SHALL have parameter DATA_ADDR_WIDTH, default 4, data/coef pointer field width.
REQ-004 SHALL have parameter INSTR_ADDR_WIDTH, default 4, program address width; depth = 2**INSTR_ADDR_WIDTH.
REQ-005 SHALL derive INSTR_WIDTH = 2 + VEC_ID_WIDTH + 2*REGFILE_ADDR_WIDTH + 3*DATA_ADDR_WIDTH (23 at defaults).
REQ-006 clk  input  1  the single clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 prog  input  1  program mode; high = loading, low = run.
REQ-009 ld_valid  input  1  load word valid.
REQ-010 ld_ready  output  1  loader accepts word.
REQ-011 ld_word  input  INSTR_WIDTH  instruction being loaded.
REQ-012 ld_last  input  1  marks final word of program.
REQ-013 pc  input  INSTR_ADDR_WIDTH  controller program counter.
REQ-014 fetch  input  1  controller fetch strobe.
REQ-015 instr_word  output  INSTR_WIDTH  instruction delivered to controller.
REQ-016 prog_len  output  INSTR_ADDR_WIDTH+1  number of valid words stored.
REQ-017 prog_done  output  1  program loaded and valid.
REQ-018 ld_err  output  1  sticky load error.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, RUN, ERR.
REQ-020 IDLE: prog=1 -> LOAD with write pointer wptr cleared and prog_len cleared in the same edge.
REQ-021 LOAD: ld_ready SHALL be 1; transfer occurs on ld_valid & ld_ready; word written to mem[wptr], wptr++, prog_len++.
REQ-022 LOAD: transfer with ld_last=1 -> RUN next cycle, prog_done=1, ld_ready=0.
REQ-023 LOAD: transfer at wptr = depth-1 without ld_last -> ERR (overflow); that word is still stored.
REQ-024 LOAD: prog falling before an ld_last transfer -> ERR (truncated program).
REQ-025 ERR: ld_err=1, prog_done=0, ld_ready=0; prog rising edge -> LOAD, clearing ld_err, wptr, prog_len.
REQ-026 RUN: prog rising edge -> LOAD, prog_done drops same cycle LOAD is entered; stored contents are overwritten progressively.
REQ-027 Reads SHALL be honoured only in RUN with prog=0; fetch=1 in cycle N -> instr_word = mem[pc] registered at edge N+1 (one-cycle latency).
REQ-028 instr_word SHALL hold its value when fetch=0.
REQ-029 fetch with pc >= prog_len, or fetch outside RUN, SHALL load instr_word with all zeros.
REQ-030 Simultaneous load write and fetch cannot occur (disjoint states); no read-during-write bypass is required.
REQ-031 prog_len SHALL saturate at depth (16 at defaults); wptr wraps never occurs (ERR first).

Reset
REQ-032 rst SHALL asynchronously force state=IDLE, wptr=0, prog_len=0, prog_done=0, ld_err=0, ld_ready=0, instr_word=0.
REQ-033 Memory array contents SHALL NOT be reset; reset mid-LOAD discards the load (prog_len=0).
REQ-034 After rst release with prog already high, SHALL enter LOAD on the first edge (level, not edge, check in IDLE).

Structure
REQ-035 Shared package SHALL hold INSTR_WIDTH derivation and the FSM state encoding (2-bit: IDLE=0, LOAD=1, RUN=2, ERR=3).
REQ-036 Storage SHALL be a sub-module ctrl_imem: depth x INSTR_WIDTH simple dual-port, synchronous write, registered read, no reset.

Verification
REQ-037 Load 5 words 0x000001..0x000005, last on 5th -> prog_len=5, prog_done=1; fetch pc=0..4 -> instr_word 0x000001..0x000005 one cycle after each fetch.
REQ-038 Load 16 words without ld_last -> ld_err=1 after 16th transfer, prog_done=0, prog_len=16.
REQ-039 Load 3 words then drop prog -> ERR, ld_err=1; re-raise prog -> ld_err=0, ld_ready=1, prog_len=0.
REQ-040 After 4-word program, fetch pc=7 -> instr_word=0; fetch=0 for 3 cycles -> instr_word unchanged.
REQ-041 Assert rst mid-LOAD after 2 words -> all outputs at reset values immediately, without waiting for clk.
REQ-042 ld_valid toggled randomly during LOAD with 8-word program -> exactly 8 words stored in order, readback matches.
